dmem_arbiter: RTL and testbench

- Sequencer and arbiter in front of a single-port, word-wide, synchronous-read data RAM.
- Shares the RAM between the CPU MEM stage and a host port used by the board I/O to preload operands and read results.
- Converts CPU byte/half/word accesses into byte-enabled word cycles.
- Splits misaligned accesses into two word cycles and stalls the pipeline until each access completes.

---
 rtl/dmem_pkg.sv | 49 ++++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared access-type codes, FSM states and byte-lane helpers for the
// data-memory sequencer.
package dmem_pkg;

   localparam logic [2:0] RW_B  = 3'b000;
   localparam logic [2:0] RW_H  = 3'b001;
   localparam logic [2:0] RW_W  = 3'b010;
   localparam logic [2:0] RW_BU = 3'b100;
   localparam logic [2:0] RW_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CPU1,
      S_CPU2,
      S_CRESP,
      S_HOST,
      S_HRESP
   } state_t;

   // Lane k sits at bits [31-8k:24-8k]; byte offset k of a word lands in lane k.
   function automatic int lane_base(input logic [1:0] k);
      return 24 - 8 * int'(k);
   endfunction

   function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] k);
      return w[lane_base(k) +: 8];
   endfunction

   function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] k,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = w;
      r[lane_base(k) +: 8] = b;
      return r;
   endfunction

   // Unlisted codes: stores act as W, loads act as HU.
   function automatic int unsigned access_size(input logic [2:0] t, input logic is_store);
      int unsigned sz;
      case (t)
         RW_B, RW_BU: sz = 1;
         RW_H, RW_HU: sz = 2;
         RW_W:        sz = 4;
         default:     sz = is_store ? 4 : 2;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane placement for stores and lane extraction plus
// sign/zero extension for loads, across a lo/hi word pair.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] st_data,
   input  logic [2:0]  st_type,
   input  logic [1:0]  st_off,
   output logic [31:0] st_lo_data,
   output logic [31:0] st_hi_data,
   output logic [0:3]  st_lo_be,
   output logic [0:3]  st_hi_be,
   input  logic [31:0] ld_lo,
   input  logic [31:0] ld_hi,
   input  logic [2:0]  ld_type,
   input  logic [1:0]  ld_off,
   output logic [31:0] ld_result
);

   always_comb begin
      int unsigned sz;
      logic [2:0]  p;
      st_lo_data = '0;
      st_hi_data = '0;
      st_lo_be   = '0;
      st_hi_be   = '0;
      sz = access_size(st_type, 1'b1);
      for (int unsigned i = 0; i < 4; i++) begin
         p = 3'(st_off) + 3'(i);
         if (i < sz) begin
            if (!p[2]) begin
               st_lo_data = put_lane(st_lo_data, p[1:0], st_data[8*i +: 8]);
               st_lo_be[p[1:0]] = 1'b1;
            end else begin
               st_hi_data = put_lane(st_hi_data, p[1:0], st_data[8*i +: 8]);
               st_hi_be[p[1:0]] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      logic [2:0]  p;
      logic [31:0] raw;
      raw       = '0;
      ld_result = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         p = 3'(ld_off) + 3'(i);
         raw[8*i +: 8] = p[2] ? get_lane(ld_hi, p[1:0]) : get_lane(ld_lo, p[1:0]);
      end
      case (ld_type)
         RW_B:    ld_result = {{24{raw[7]}}, raw[7:0]};
         RW_BU:   ld_result = {24'b0, raw[7:0]};
         RW_H:    ld_result = {{16{raw[15]}}, raw[15:0]};
         RW_W:    ld_result = raw;
         default: ld_result = {16'b0, raw[15:0]};
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data RAM between the CPU MEM stage and the host port,
// sequencing CPU accesses into one or two byte-enabled word cycles.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W           = 6,
   parameter bit          RESET_GRANT_HOST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [2:0]        cpu_type,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [31:0]       host_wdata,
   output logic [31:0]       host_rdata,
   output logic              host_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [0:3]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t            state, state_nx;
   logic              last_grant, last_grant_nx;
   logic              lat_we, lat_we_nx;
   logic [2:0]        lat_type, lat_type_nx;
   logic [1:0]        lat_off, lat_off_nx;
   logic              lat_split, lat_split_nx;
   logic [ADDR_W-1:0] hi_addr, hi_addr_nx;
   logic [0:3]        hi_be, hi_be_nx;
   logic [31:0]       hi_wdata, hi_wdata_nx;
   logic [31:0]       first_word, first_word_nx;

   logic              en_nx, we_nx;
   logic [0:3]        be_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [31:0]       wdata_nx;

   logic [ADDR_W-1:0] cpu_idx;
   logic              cpu_split;
   logic [31:0]       st_lo_data, st_hi_data, ld_lo, ld_result;
   logic [0:3]        st_lo_be, st_hi_be;
   logic              unused_addr_hi;

   assign cpu_idx        = cpu_addr[ADDR_W+1:2];
   assign cpu_split      = (32'(cpu_addr[1:0]) + access_size(cpu_type, cpu_we)) > 32'd4;
   assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];
   assign ld_lo          = lat_split ? first_word : mem_rdata;

   dmem_lane_align u_align (
      .st_data    (cpu_wdata),
      .st_type    (cpu_type),
      .st_off     (cpu_addr[1:0]),
      .st_lo_data (st_lo_data),
      .st_hi_data (st_hi_data),
      .st_lo_be   (st_lo_be),
      .st_hi_be   (st_hi_be),
      .ld_lo      (ld_lo),
      .ld_hi      (mem_rdata),
      .ld_type    (lat_type),
      .ld_off     (lat_off),
      .ld_result  (ld_result)
   );

   assign cpu_done   = (state == S_CRESP);
   assign cpu_rdata  = (cpu_done && !lat_we) ? ld_result : '0;
   assign cpu_stall  = cpu_req & ~cpu_done;
   assign host_ack   = (state == S_HRESP);
   assign host_rdata = host_ack ? mem_rdata : '0;

   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      lat_we_nx     = lat_we;
      lat_type_nx   = lat_type;
      lat_off_nx    = lat_off;
      lat_split_nx  = lat_split;
      hi_addr_nx    = hi_addr;
      hi_be_nx      = hi_be;
      hi_wdata_nx   = hi_wdata;
      first_word_nx = first_word;
      en_nx         = 1'b0;
      we_nx         = 1'b0;
      be_nx         = '0;
      addr_nx       = '0;
      wdata_nx      = '0;
      case (state)
         S_IDLE: begin
            // The second word of a split store is placed at grant time, so
            // the CPU may change its inputs once the first cycle is issued.
            if (cpu_req && (!host_req || last_grant)) begin
               state_nx      = S_CPU1;
               last_grant_nx = 1'b0;
               lat_we_nx     = cpu_we;
               lat_type_nx   = cpu_type;
               lat_off_nx    = cpu_addr[1:0];
               lat_split_nx  = cpu_split;
               hi_addr_nx    = cpu_idx + ADDR_W'(1);
               hi_be_nx      = cpu_we ? st_hi_be : '1;
               hi_wdata_nx   = cpu_we ? st_hi_data : '0;
               en_nx         = 1'b1;
               we_nx         = cpu_we;
               be_nx         = cpu_we ? st_lo_be : '1;
               addr_nx       = cpu_idx;
               wdata_nx      = cpu_we ? st_lo_data : '0;
            end else if (host_req) begin
               state_nx      = S_HOST;
               last_grant_nx = 1'b1;
               en_nx         = 1'b1;
               we_nx         = host_we;
               be_nx         = '1;
               addr_nx       = host_addr;
               wdata_nx      = host_wdata;
            end
         end
         S_CPU1: begin
            if (lat_split) begin
               state_nx = S_CPU2;
               en_nx    = 1'b1;
               we_nx    = lat_we;
               be_nx    = hi_be;
               addr_nx  = hi_addr;
               wdata_nx = hi_wdata;
            end else begin
               state_nx = S_CRESP;
            end
         end
         S_CPU2: begin
            first_word_nx = mem_rdata;
            state_nx      = S_CRESP;
         end
         S_CRESP: state_nx = S_IDLE;
         S_HOST:  state_nx = S_HRESP;
         S_HRESP: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= RESET_GRANT_HOST;
         lat_we     <= 1'b0;
         lat_type   <= '0;
         lat_off    <= '0;
         lat_split  <= 1'b0;
         hi_addr    <= '0;
         hi_be      <= '0;
         hi_wdata   <= '0;
         first_word <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         lat_we     <= lat_we_nx;
         lat_type   <= lat_type_nx;
         lat_off    <= lat_off_nx;
         lat_split  <= lat_split_nx;
         hi_addr    <= hi_addr_nx;
         hi_be      <= hi_be_nx;
         hi_wdata   <= hi_wdata_nx;
         first_word <= first_word_nx;
         mem_en     <= en_nx;
         mem_we     <= we_nx;
         mem_be     <= be_nx;
         mem_addr   <= addr_nx;
         mem_wdata  <= wdata_nx;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-enabled
// synchronous-read RAM attached to the memory port.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we;
   logic [2:0]    cpu_type;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
   logic          cpu_done, cpu_stall;
   logic          host_req, host_we;
   logic [AW-1:0] host_addr;
   logic [31:0]   host_wdata, host_rdata;
   logic          host_ack;
   logic          mem_en, mem_we;
   logic [0:3]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .RESET_GRANT_HOST(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_type   (cpu_type),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_done   (cpu_done),
      .cpu_stall  (cpu_stall),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .host_ack   (host_ack),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // RAM: lane k = bits [31-8k:24-8k], enabled by mem_be[k]; read-before-write.
   logic [31:0] ram [0:63];
   always @(posedge clk) begin
      logic [31:0] w;
      if (mem_en) begin
         w = ram[mem_addr];
         if (mem_we) begin
            for (int k = 0; k < 4; k++)
               if (mem_be[k]) w[31-8*k -: 8] = mem_wdata[31-8*k -: 8];
            ram[mem_addr] <= w;
         end
         mem_rdata <= ram[mem_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic host_xfer(input string tag, input logic we, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [31:0] exp, input bit chk_data);
      int lat = 0;
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
      do begin @(negedge clk); lat++; end while (!host_ack && lat < 20);
      check({tag, "_lat"}, lat, 2);
      if (chk_data) check({tag, "_rdata"}, host_rdata, exp);
      host_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_xfer(input string tag, input logic we, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input int exp_lat);
      int lat = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_type = t; cpu_addr = a; cpu_wdata = d;
      do begin @(negedge clk); lat++; end while (!cpu_done && lat < 20);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_rdata"}, cpu_rdata, exp_rd);
      cpu_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_type = RW_W; cpu_addr = '0; cpu_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ctl", 32'({mem_en, mem_we, mem_be, cpu_done, host_ack}), 32'h0);
      check("rst_addr", 32'(mem_addr), 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_rdata", cpu_rdata | host_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_en", 32'(mem_en), 32'h0);

      // Tie from reset: CPU SW 0x20 wins, host read of word 8 waits.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = RW_W; cpu_addr = 32'h20; cpu_wdata = 32'hAABBCCDD;
      host_req = 1'b1; host_we = 1'b0; host_addr = 6'd8;
      #1 check("sw_stall_T", 32'(cpu_stall), 32'h1);
      @(negedge clk);
      check("sw_c1_ctl", 32'({mem_en, mem_we, mem_be}), 32'b11_1111);
      check("sw_c1_addr", 32'(mem_addr), 32'd8);
      check("sw_c1_wdata", mem_wdata, 32'hDDCCBBAA);
      check("sw_stall_T1", 32'(cpu_stall), 32'h1);
      @(negedge clk);
      check("sw_done", 32'(cpu_done), 32'h1);
      check("sw_rdata", cpu_rdata, 32'h0);
      check("sw_stall_T2", 32'(cpu_stall), 32'h0);
      check("sw_t2_ctl", 32'({mem_en, mem_we, mem_be}), 32'h0);
      check("tie_host_wait", 32'(host_ack), 32'h0);
      cpu_req = 1'b0;
      @(negedge clk);
      // CPU re-requests while host still pending: host must win now.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_type = RW_W; cpu_addr = 32'h20;
      @(negedge clk);
      check("tie2_host_ctl", 32'({mem_en, mem_we, mem_be}), 32'b10_1111);
      check("tie2_host_addr", 32'(mem_addr), 32'd8);
      check("tie2_cpu_stall", 32'(cpu_stall), 32'h1);
      @(negedge clk);
      check("tie2_host_ack", 32'(host_ack), 32'h1);
      check("tie2_host_rdata", host_rdata, 32'hDDCCBBAA);
      host_req = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!cpu_done && lat < 20);
      check("tie2_cpu_lat", lat, 3);
      check("tie2_cpu_rdata", cpu_rdata, 32'hAABBCCDD);
      cpu_req = 1'b0;
      @(negedge clk);

      // Misaligned LW at 0x23.
      host_xfer("pre8", 1'b1, 6'd8, 32'h000000DD, 32'h0, 1'b0);
      host_xfer("pre9", 1'b1, 6'd9, 32'hCCBBAA00, 32'h0, 1'b0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_type = RW_W; cpu_addr = 32'h23;
      @(negedge clk);
      check("lw_c1_ctl", 32'({mem_en, mem_we, mem_be}), 32'b10_1111);
      check("lw_c1_addr", 32'(mem_addr), 32'd8);
      @(negedge clk);
      check("lw_c2_addr", 32'({mem_en, mem_addr}), 32'({1'b1, 6'd9}));
      check("lw_c2_done", 32'(cpu_done), 32'h0);
      @(negedge clk);
      check("lw_done", 32'(cpu_done), 32'h1);
      check("lw_rdata", cpu_rdata, 32'hAABBCCDD);
      check("lw_idle_en", 32'(mem_en), 32'h0);
      cpu_req = 1'b0;
      @(negedge clk);

      // SH 0x8001 at offset 3 (upper store bits must be ignored).
      host_xfer("pre3", 1'b1, 6'd3, 32'h0, 32'h0, 1'b0);
      host_xfer("pre4", 1'b1, 6'd4, 32'h0, 32'h0, 1'b0);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = RW_H; cpu_addr = 32'h0F; cpu_wdata = 32'hDEAD8001;
      @(negedge clk);
      check("sh_c1_ctl", 32'({mem_en, mem_we, mem_be}), 32'b11_0001);
      check("sh_c1_addr", 32'(mem_addr), 32'd3);
      check("sh_c1_wdata", mem_wdata, 32'h00000001);
      @(negedge clk);
      check("sh_c2_ctl", 32'({mem_en, mem_we, mem_be}), 32'b11_1000);
      check("sh_c2_addr", 32'(mem_addr), 32'd4);
      check("sh_c2_wdata", mem_wdata, 32'h80000000);
      @(negedge clk);
      check("sh_done", 32'(cpu_done), 32'h1);
      check("sh_rdata", cpu_rdata, 32'h0);
      cpu_req = 1'b0;
      @(negedge clk);
      cpu_xfer("lh", 1'b0, RW_H, 32'h0F, 32'h0, 32'hFFFF8001, 3);
      cpu_xfer("lhu", 1'b0, RW_HU, 32'h0F, 32'h0, 32'h00008001, 3);
      cpu_xfer("lx011", 1'b0, 3'b011, 32'h0F, 32'h0, 32'h00008001, 3);
      cpu_xfer("lb", 1'b0, RW_B, 32'h10, 32'h0, 32'hFFFFFF80, 2);
      cpu_xfer("lbu", 1'b0, RW_BU, 32'h10, 32'h0, 32'h00000080, 2);
      host_xfer("rd3", 1'b0, 6'd3, 32'h0, 32'h00000001, 1'b1);
      host_xfer("rd4", 1'b0, 6'd4, 32'h0, 32'h80000000, 1'b1);

      // Unlisted store code acts as a full word.
      cpu_xfer("sx111", 1'b1, 3'b111, 32'h28, 32'h01020304, 32'h0, 2);
      host_xfer("rd10", 1'b0, 6'd10, 32'h0, 32'h04030201, 1'b1);

      // Split LW at word 63 wraps to word 0.
      host_xfer("pre63", 1'b1, 6'd63, 32'h11223344, 32'h0, 1'b0);
      host_xfer("pre0", 1'b1, 6'd0, 32'h55667788, 32'h0, 1'b0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_type = RW_W; cpu_addr = 32'hFD;
      @(negedge clk);
      check("wrap_c1_addr", 32'(mem_addr), 32'd63);
      @(negedge clk);
      check("wrap_c2", 32'({mem_en, mem_addr}), 32'({1'b1, 6'd0}));
      @(negedge clk);
      check("wrap_done", 32'(cpu_done), 32'h1);
      check("wrap_rdata", cpu_rdata, 32'h55443322);
      cpu_req = 1'b0;
      @(negedge clk);

      // Reset during CPU2 of a split store: only the first word lands.
      host_xfer("pre1", 1'b1, 6'd1, 32'h0, 32'h0, 1'b0);
      host_xfer("pre2", 1'b1, 6'd2, 32'h0, 32'h0, 1'b0);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = RW_W; cpu_addr = 32'h05; cpu_wdata = 32'h12345678;
      @(negedge clk);
      check("rs_c1_be", 32'({mem_be, mem_addr}), 32'({4'b0111, 6'd1}));
      check("rs_c1_wdata", mem_wdata, 32'h00785634);
      @(negedge clk);
      check("rs_c2_ctl", 32'({mem_en, mem_we, mem_be, mem_addr}), 32'({6'b11_1000, 6'd2}));
      rst_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      check("rs_outs", 32'({mem_en, mem_we, mem_be, cpu_done, host_ack, mem_addr}), 32'h0);
      check("rs_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      host_xfer("rs_rd1", 1'b0, 6'd1, 32'h0, 32'h00785634, 1'b1);
      host_xfer("rs_rd2", 1'b0, 6'd2, 32'h0, 32'h00000000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
